// File: rtl/jmb_9x9_line_buffer.sv
// Column feeder for jmb_9x9_filter: turns a raster pixel stream into 9-tall
// vertical column words using eight line memories and one output register.
module jmb_9x9_line_buffer #(
  parameter int DATA_WIDTH   = 8,
  parameter int IMAGE_WIDTH  = 10,
  parameter int IMAGE_HEIGHT = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    valid_in,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic                    ready_out,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic [9*DATA_WIDTH-1:0] data_out,
  output logic                    eol_out,
  output logic                    eof_out
);

  localparam int CW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  logic [CW-1:0]           col_q, col_d;
  logic [RW-1:0]           row_q, row_d;
  logic                    valid_q, valid_d;
  logic [9*DATA_WIDTH-1:0] data_q, data_d;
  logic                    eol_q, eol_d;
  logic                    eof_q, eof_d;

  // line_q[0] is the previous row, line_q[7] is eight rows up
  logic [DATA_WIDTH-1:0]   line_q [0:7][0:IMAGE_WIDTH-1];
  logic [9*DATA_WIDTH-1:0] vec;

  logic accept;
  logic load;
  logic col_last;
  logic row_last;

  // reset term keeps the upstream side ready while the output register clears
  assign ready_out = reset || ready_in || !valid_q;
  assign accept    = valid_in && ready_out && !reset;
  assign col_last  = (col_q == CW'(IMAGE_WIDTH - 1));
  assign row_last  = (row_q == RW'(IMAGE_HEIGHT - 1));
  assign load      = accept && (row_q >= RW'(8));

  assign vec[DATA_WIDTH-1:0] = data_in;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_tap
      assign vec[(gi+1)*DATA_WIDTH +: DATA_WIDTH] = line_q[gi][col_q];
    end
  endgenerate

  // Line memories are never reset; priming rows overwrite every entry first.
  always_ff @(posedge clock) begin
    if (accept) begin
      line_q[0][col_q] <= data_in;
      for (int i = 1; i < 8; i++) begin
        line_q[i][col_q] <= line_q[i-1][col_q];
      end
    end
  end

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    valid_d = valid_q;
    data_d  = data_q;
    eol_d   = eol_q;
    eof_d   = eof_q;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = vec;
      eol_d   = col_last;
      eof_d   = col_last && row_last;
    end else if (ready_in) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign eol_out   = eol_q;
  assign eof_out   = eof_q;

endmodule

// File: tb/tb_jmb_9x9_line_buffer.sv
// Directed bench for jmb_9x9_line_buffer: scoreboard of expected column words
// built from the pixel values sent, checked every cycle the output is valid.
module tb_jmb_9x9_line_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [7:0]  data_in;
  logic        ready_out;
  logic        valid_out;
  logic        ready_in;
  logic [71:0] data_out;
  logic        eol_out;
  logic        eof_out;

  jmb_9x9_line_buffer #(
    .DATA_WIDTH  (8),
    .IMAGE_WIDTH (10),
    .IMAGE_HEIGHT(10)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .valid_in (valid_in),
    .data_in  (data_in),
    .ready_out(ready_out),
    .valid_out(valid_out),
    .ready_in (ready_in),
    .data_out (data_out),
    .eol_out  (eol_out),
    .eof_out  (eof_out)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [71:0] data;
    logic        eol;
    logic        eof;
  } word_t;

  word_t       sb[$];
  logic [71:0] got[$];
  int          checks = 0;
  int          errors = 0;
  int          stall  = 0;
  int          b_row  = 0;
  int          b_col  = 0;
  int          n_eol  = 0;
  int          n_eof  = 0;
  bit          model_valid = 1'b0;

  localparam logic [71:0] F1_FIRST = 72'h01_0B_15_1F_29_33_3D_47_51;
  localparam logic [71:0] F1_LAST  = 72'h14_1E_28_32_3C_46_50_5A_64;
  localparam logic [71:0] F2_FIRST = 72'h65_6F_79_83_8D_97_A1_AB_B5;
  localparam logic [71:0] F2_LAST  = 72'h78_82_8C_96_A0_AA_B4_BE_C8;

  // Column word for pixel v in a raster of width 10: v in the LSB byte, v-80 in the MSB byte.
  function automatic logic [71:0] col_word(input int v);
    logic [71:0] w;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(v - 10*k);
    return w;
  endfunction

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(output bit acc);
    bit    fire;
    bit    load;
    word_t w;
    if (stall > 0) begin
      ready_in = 1'b0;
      stall--;
    end else begin
      ready_in = 1'b1;
    end
    @(negedge clock);
    check("valid_out", 72'(valid_out), 72'(model_valid));
    check("ready_out", 72'(ready_out), 72'(ready_in || !model_valid));
    if (model_valid) begin
      check("sb_size", 72'(sb.size()), 72'd1);
      if (sb.size() > 0) begin
        w = sb[0];
        check("data_out", data_out, w.data);
        check("eol_out", 72'(eol_out), 72'(w.eol));
        check("eof_out", 72'(eof_out), 72'(w.eof));
      end
    end
    acc  = valid_in && (ready_in || !model_valid);
    fire = model_valid && ready_in;
    load = acc && (b_row >= 8);
    if (fire) begin
      got.push_back(data_out);
      if (eol_out) n_eol++;
      if (eof_out) n_eof++;
    end
    @(posedge clock);
    #1;
    if (fire && sb.size() > 0) void'(sb.pop_front());
    if (load) sb.push_back('{col_word(int'(data_in)), b_col == 9, (b_col == 9) && (b_row == 9)});
    model_valid = load || (model_valid && !ready_in);
    if (acc) begin
      if (b_col == 9) begin
        b_col = 0;
        b_row = (b_row == 9) ? 0 : b_row + 1;
      end else begin
        b_col++;
      end
    end
  endtask

  task automatic send_pixel(input int v, input bit bubbles, input int stall_at);
    bit acc;
    int guard;
    int gaps;
    gaps = 0;
    if (bubbles) begin
      while (gaps < 3 && $urandom_range(0, 2) == 0) begin
        valid_in = 1'b0;
        cycle(acc);
        gaps++;
      end
    end
    valid_in = 1'b1;
    data_in  = 8'(v);
    acc      = 1'b0;
    guard    = 0;
    while (!acc) begin
      cycle(acc);
      guard++;
      if (!acc && guard >= 20) begin
        check("accept_timeout", 72'(guard), 72'd0);
        break;
      end
    end
    if (acc && v == stall_at) stall = 5;
  endtask

  task automatic send_frame(input int base, input bit bubbles, input int stall_at);
    for (int i = 1; i <= 100; i++) send_pixel(base + i, bubbles, stall_at);
  endtask

  task automatic idle(input int n);
    bit acc;
    valid_in = 1'b0;
    repeat (n) cycle(acc);
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b1;
    valid_in = 1'b1;
    data_in  = 8'hAA;
    ready_in = 1'b1;
    repeat (n) @(posedge clock);
    #1;
    check("rst_valid_out", 72'(valid_out), 72'd0);
    check("rst_data_out", data_out, 72'd0);
    check("rst_eol_out", 72'(eol_out), 72'd0);
    check("rst_eof_out", 72'(eof_out), 72'd0);
    check("rst_ready_out", 72'(ready_out), 72'd1);
    reset       = 1'b0;
    valid_in    = 1'b0;
    sb.delete();
    got.delete();
    model_valid = 1'b0;
    b_row       = 0;
    b_col       = 0;
    n_eol       = 0;
    n_eof       = 0;
  endtask

  task automatic frame_checks(input string tag, input int frames);
    check({tag, "_words"}, 72'(got.size()), 72'(20 * frames));
    if (got.size() >= 20) begin
      check({tag, "_first"}, got[0], F1_FIRST);
      check({tag, "_last"}, got[19], F1_LAST);
    end
    if (frames == 2 && got.size() >= 40) begin
      check({tag, "_f2_first"}, got[20], F2_FIRST);
      check({tag, "_f2_last"}, got[39], F2_LAST);
    end
    check({tag, "_eol_count"}, 72'(n_eol), 72'(2 * frames));
    check({tag, "_eof_count"}, 72'(n_eof), 72'(frames));
    $display("%s: %0d words, %0d eol, %0d eof", tag, got.size(), n_eol, n_eof);
    got.delete();
    n_eol = 0;
    n_eof = 0;
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    ready_in = 1'b1;

    do_reset(2);

    send_frame(0, 1'b0, 0);
    idle(3);
    frame_checks("continuous", 1);

    send_frame(0, 1'b0, 85);
    idle(3);
    frame_checks("backpressure", 1);

    send_frame(0, 1'b1, 0);
    idle(3);
    frame_checks("bubbles", 1);

    send_frame(0, 1'b0, 0);
    send_frame(100, 1'b0, 0);
    idle(3);
    frame_checks("back_to_back", 2);

    for (int i = 1; i <= 50; i++) send_pixel(i, 1'b0, 0);
    do_reset(1);
    send_frame(0, 1'b0, 0);
    idle(3);
    frame_checks("reset_mid_frame", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
